// File: rtl/uart_packet_decoder.sv
// uart_packet_decoder: assembles UART bytes into a control/output/frequency packet and publishes it atomically.
// Optional UART_PACKET_CHECKSUM_EN appends an XOR checksum byte that gates publication.
module uart_packet_decoder #(
  parameter int DATA_BIT    = 32,
  parameter int PACK_NUM    = 9,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          i_data,
  input  logic                i_rx_done_tick,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic [3:0]          o_sel_out,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_mode,
  output logic                o_done_tick,
  output logic                o_err_tick
);
  localparam int NB = DATA_BIT / 8;
  localparam int CW = $clog2(PACK_NUM + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
`ifdef UART_PACKET_CHECKSUM_EN
  localparam int LAST = PACK_NUM;
`else
  localparam int LAST = PACK_NUM - 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_PUB} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [6:0]          ctrl_sh_q, ctrl_sh_d, ctrl_q, ctrl_d;
  logic [DATA_BIT-1:0] out_sh_q, out_sh_d, freq_sh_q, freq_sh_d;
  logic [DATA_BIT-1:0] out_pat_q, out_pat_d, freq_pat_q, freq_pat_d;
  logic                done_q, done_d, err_q, err_d;
  logic                pub_ok, chk_byte;

`ifdef UART_PACKET_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       chk_ok_q, chk_ok_d;
  assign pub_ok   = chk_ok_q;
  assign chk_byte = byte_cnt_q == CW'(LAST);
`else
  assign pub_ok   = 1'b1;
  assign chk_byte = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    ctrl_sh_d  = ctrl_sh_q;
    out_sh_d   = out_sh_q;
    freq_sh_d  = freq_sh_q;
    ctrl_d     = ctrl_q;
    out_pat_d  = out_pat_q;
    freq_pat_d = freq_pat_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef UART_PACKET_CHECKSUM_EN
    sum_d      = sum_q;
    chk_ok_d   = chk_ok_q;
`endif
    if (state_q == S_PUB) begin
      state_d = S_IDLE;
      if (pub_ok) begin
        ctrl_d     = ctrl_sh_q;
        out_pat_d  = out_sh_q;
        freq_pat_d = freq_sh_q;
        done_d     = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // A strobe outside S_RECV is always byte 0 of a new packet, including during publish.
    if (i_rx_done_tick && state_q != S_RECV) begin
      ctrl_sh_d  = i_data[6:0];
      byte_cnt_d = CW'(1);
      timer_d    = '0;
      state_d    = S_RECV;
`ifdef UART_PACKET_CHECKSUM_EN
      sum_d      = i_data;
`endif
    end else if (state_q == S_RECV) begin
      if (i_rx_done_tick) begin
        timer_d    = '0;
        byte_cnt_d = byte_cnt_q + 1'b1;
        if (!chk_byte) begin
          if (byte_cnt_q <= CW'(NB)) out_sh_d = DATA_BIT'({out_sh_q, i_data});
          else freq_sh_d = DATA_BIT'({freq_sh_q, i_data});
        end
`ifdef UART_PACKET_CHECKSUM_EN
        sum_d    = sum_q ^ i_data;
        chk_ok_d = sum_q == i_data;
`endif
        if (byte_cnt_q == CW'(LAST)) state_d = S_PUB;
      end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d      = 1'b1;
        byte_cnt_d = '0;
        state_d    = S_IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      ctrl_sh_q  <= '0;
      out_sh_q   <= '0;
      freq_sh_q  <= '0;
      ctrl_q     <= '0;
      out_pat_q  <= '0;
      freq_pat_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      ctrl_sh_q  <= ctrl_sh_d;
      out_sh_q   <= out_sh_d;
      freq_sh_q  <= freq_sh_d;
      ctrl_q     <= ctrl_d;
      out_pat_q  <= out_pat_d;
      freq_pat_q <= freq_pat_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef UART_PACKET_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      chk_ok_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      chk_ok_q <= chk_ok_d;
    end
  end
`endif

  assign o_output_pattern = out_pat_q;
  assign o_freq_pattern   = freq_pat_q;
  assign o_sel_out        = ctrl_q[3:0];
  assign o_start          = ctrl_q[4];
  assign o_stop           = ctrl_q[5];
  assign o_mode           = ctrl_q[6];
  assign o_done_tick      = done_q;
  assign o_err_tick       = err_q;
endmodule

// File: tb/tb_uart_packet_decoder.sv
// tb_uart_packet_decoder: directed packets checked every cycle against a byte-queue packet model.
module tb_uart_packet_decoder;
  localparam int DB = 32, PN = 9, T = 20, NB = DB / 8;
`ifdef UART_PACKET_CHECKSUM_EN
  localparam int TOTAL = PN + 1;
`else
  localparam int TOTAL = PN;
`endif

  logic clk = 1'b0, rst_n = 1'b0, i_rx_done_tick = 1'b0;
  logic [7:0] i_data = '0;
  logic [DB-1:0] o_output_pattern, o_freq_pattern;
  logic [3:0] o_sel_out;
  logic o_start, o_stop, o_mode, o_done_tick, o_err_tick;

  uart_packet_decoder #(.DATA_BIT(DB), .PACK_NUM(PN), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_rx_done_tick(i_rx_done_tick),
    .o_output_pattern(o_output_pattern), .o_freq_pattern(o_freq_pattern),
    .o_sel_out(o_sel_out), .o_start(o_start), .o_stop(o_stop), .o_mode(o_mode),
    .o_done_tick(o_done_tick), .o_err_tick(o_err_tick)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0] tx_q[$];

  logic [7:0] pkt[$];
  int gap;
  logic pend_pub, pend_err, exp_done, exp_err;
  logic [6:0] pend_ctrl, exp_ctrl;
  logic [DB-1:0] pend_out, pend_freq, exp_out, exp_freq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic decode();
    logic [7:0] x;
    x = '0;
    pend_ctrl = pkt[0][6:0];
    pend_out  = '0;
    pend_freq = '0;
    for (int i = 1; i <= NB; i++) pend_out = (pend_out << 8) | DB'(pkt[i]);
    for (int i = NB + 1; i <= 2 * NB; i++) pend_freq = (pend_freq << 8) | DB'(pkt[i]);
    for (int i = 0; i < PN; i++) x ^= pkt[i];
`ifdef UART_PACKET_CHECKSUM_EN
    pend_pub = x == pkt[PN];
    pend_err = x != pkt[PN];
`else
    pend_pub = 1'b1;
`endif
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      pkt.delete();
      gap = 0;
      {pend_pub, pend_err, exp_done, exp_err} = '0;
      {pend_ctrl, exp_ctrl, pend_out, pend_freq, exp_out, exp_freq} = '0;
    end else begin
      exp_done = pend_pub;
      exp_err  = pend_err;
      if (pend_pub) {exp_ctrl, exp_out, exp_freq} = {pend_ctrl, pend_out, pend_freq};
      pend_pub = 1'b0;
      pend_err = 1'b0;
      if (i_rx_done_tick) begin
        pkt.push_back(i_data);
        gap = 0;
        if (pkt.size() == TOTAL) begin
          decode();
          pkt.delete();
        end
      end else if (pkt.size() > 0) begin
        gap++;
        if (gap == T) begin
          exp_err = 1'b1;
          pkt.delete();
          gap = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("done_tick", o_done_tick, exp_done);
    chk("err_tick", o_err_tick, exp_err);
    chk("output_pattern", o_output_pattern, exp_out);
    chk("freq_pattern", o_freq_pattern, exp_freq);
    chk("ctrl", {o_mode, o_stop, o_start, o_sel_out}, exp_ctrl);
    if (o_done_tick) done_cnt++;
    if (o_err_tick) err_cnt++;
  end

  task automatic mk_pkt(input logic [7:0] c, input logic [DB-1:0] o, input logic [DB-1:0] f, input bit bad = 0);
    logic [7:0] x;
    logic [7:0] b[$];
    b.push_back(c);
    for (int i = NB - 1; i >= 0; i--) b.push_back(o[i*8 +: 8]);
    for (int i = NB - 1; i >= 0; i--) b.push_back(f[i*8 +: 8]);
    x = '0;
    foreach (b[i]) begin
      x ^= b[i];
      tx_q.push_back(b[i]);
    end
`ifdef UART_PACKET_CHECKSUM_EN
    tx_q.push_back(x ^ {7'd0, bad});
`else
    if (bad) tx_q.push_back(x);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input int g);
    for (int i = 0; i < n; i++) begin
      i_data = tx_q.pop_front();
      i_rx_done_tick = 1'b1;
      idle(1);
      if (g > 0) begin
        i_rx_done_tick = 1'b0;
        idle(g);
      end
    end
    i_rx_done_tick = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("rst_out", o_output_pattern, 0);
    chk("rst_freq", o_freq_pattern, 0);
    chk("rst_ctrl", {o_mode, o_stop, o_start, o_sel_out, o_done_tick, o_err_tick}, 0);
    rst_n = 1'b1;
    idle(2);

    mk_pkt(8'h51, 32'hDEADBEEF, 32'h0000FFFF);
    send(TOTAL, 0);
    chk("t1_done_early", o_done_tick, 0);
    idle(1);
    chk("t1_done", o_done_tick, 1);
    chk("t1_sel", o_sel_out, 1);
    chk("t1_start_stop_mode", {o_start, o_stop, o_mode}, 3'b101);
    chk("t1_out", o_output_pattern, 32'hDEADBEEF);
    chk("t1_freq", o_freq_pattern, 32'h0000FFFF);
    chk("t1_model_out", exp_out, 32'hDEADBEEF);

    err_cnt = 0;
    mk_pkt(8'h23, 32'h12345678, 32'h9ABCDEF0);
    send(4, 0);
    tx_q.delete();
    idle(T + 5);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_out_kept", o_output_pattern, 32'hDEADBEEF);
    done_cnt = 0;
    mk_pkt(8'h1A, 32'hCAFEF00D, 32'h00FF00FF);
    send(TOTAL, 2);
    idle(3);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_out", o_output_pattern, 32'hCAFEF00D);
    chk("t2_sel", o_sel_out, 4'hA);

    done_cnt = 0;
    mk_pkt(8'h05, 32'h11111111, 32'h22222222);
    mk_pkt(8'h4C, 32'hA5A55A5A, 32'h0F0F0F0F);
    send(2 * TOTAL, 0);
    idle(3);
    chk("t3_done_cnt", done_cnt, 2);
    chk("t3_out", o_output_pattern, 32'hA5A55A5A);
    chk("t3_freq", o_freq_pattern, 32'h0F0F0F0F);
    chk("t3_ctrl", {o_mode, o_stop, o_start, o_sel_out}, 7'h4C);

    done_cnt = 0;
    err_cnt = 0;
    mk_pkt(8'h3F, 32'h77777777, 32'h88888888);
    send(6, 0);
    rst_n = 1'b0;
    tx_q.delete();
    idle(2);
    chk("t4_rst_out", o_output_pattern, 0);
    chk("t4_rst_ctrl", {o_mode, o_stop, o_start, o_sel_out}, 0);
    rst_n = 1'b1;
    idle(T + 3);
    chk("t4_no_ticks", done_cnt + err_cnt, 0);
    mk_pkt(8'h37, 32'h0BADC0DE, 32'hFEEDFACE);
    send(TOTAL, 0);
    idle(3);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_out", o_output_pattern, 32'h0BADC0DE);
    chk("t4_freq", o_freq_pattern, 32'hFEEDFACE);

    done_cnt = 0;
    err_cnt = 0;
    mk_pkt(8'h62, 32'h13579BDF, 32'h2468ACE0);
    send(3, 0);
    idle(T - 1);
    send(TOTAL - 3, 0);
    idle(3);
    chk("t5_err_cnt", err_cnt, 0);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_out", o_output_pattern, 32'h13579BDF);

`ifdef UART_PACKET_CHECKSUM_EN
    done_cnt = 0;
    err_cnt = 0;
    mk_pkt(8'h01, 32'hFFFFFFFF, 32'h00000000, 1);
    send(TOTAL, 0);
    idle(1);
    chk("t6_bad_err", o_err_tick, 1);
    chk("t6_bad_done", o_done_tick, 0);
    idle(3);
    chk("t6_err_cnt", err_cnt, 1);
    chk("t6_out_kept", o_output_pattern, 32'h13579BDF);
    mk_pkt(8'h01, 32'hFFFFFFFF, 32'h00000000);
    send(TOTAL, 0);
    idle(3);
    chk("t6_done_cnt", done_cnt, 1);
    chk("t6_out", o_output_pattern, 32'hFFFFFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
